// File: rtl/pcm_stream_player.sv
// pcm_stream_player: streams fixed-rate samples from a combinational sample ROM
// between latched start/end addresses. Supports start/stop/pause, loop mode and
// a per-sample strobe. All logic runs on clk. A prescaler tick acts as the
// sample-rate clock enable.
// Optional feature macro: PCM_STREAM_PLAYER_VOLUME_EN. When it is defined, the
// design adds a volume[1:0] input that right-shifts each sample by (3-volume).
module pcm_stream_player #(
    parameter int unsigned           DATA_W    = 4,
    parameter int unsigned           ADDR_W    = 17,
    parameter int unsigned           DIV_W     = 16,
    parameter logic [DIV_W-1:0]      DIV_LIMIT = 16'h11ad
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
`ifdef PCM_STREAM_PLAYER_VOLUME_EN
    input  logic [1:0]        volume,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [ADDR_W-1:0] start_lat;
    logic [ADDR_W-1:0] end_lat;
    logic [DATA_W-1:0] shaped;

    // Sample value captured on a tick (optionally attenuated by volume)
    always_comb begin
`ifdef PCM_STREAM_PLAYER_VOLUME_EN
        shaped = rom_data >> (2'd3 - volume);
`else
        shaped = rom_data;
`endif
    end

    // Playback FSM, prescaler, address generator and sample register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            rom_addr     <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            start_lat    <= '0;
            end_lat      <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                sample  <= '0;
                div_cnt <= '0;
            end else if (start) begin
                start_lat <= start_addr;
                end_lat   <= end_addr;
                rom_addr  <= start_addr;
                div_cnt   <= '0;
                state     <= pause ? PAUSED : RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (pause) begin
                            state <= PAUSED;
                        end else if (div_cnt == DIV_LIMIT) begin
                            div_cnt      <= '0;
                            sample       <= shaped;
                            sample_valid <= 1'b1;
                            if (rom_addr == end_lat) begin
                                if (loop_en) begin
                                    rom_addr <= start_lat;
                                end else begin
                                    state <= DONE;
                                end
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (!pause) begin
                            state <= RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status flags decoded from the state register
    always_comb begin
        busy = (state == RUN) || (state == PAUSED);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_pcm_stream_player.sv
// Testbench for pcm_stream_player: directed scenarios followed by random
// control traffic. A behavioural model predicts every sample strobe into a
// scoreboard queue. A negedge monitor pops and compares each strobe and checks
// the status and address outputs.
module tb_pcm_stream_player;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 17;
    localparam int LIMIT  = 3;
    localparam int ASPACE = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0, end_addr = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] sample;
    logic              sample_valid, busy, done;
`ifdef PCM_STREAM_PLAYER_VOLUME_EN
    logic [1:0]        volume = 2'd3;
`endif

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    // model state
    bit m_active, m_held, m_fin;
    int m_pos, m_first, m_last, m_elapsed, m_sample;
    int exp_q[$];

    pcm_stream_player #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DIV_W    (16),
        .DIV_LIMIT(16'(LIMIT))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
`ifdef PCM_STREAM_PLAYER_VOLUME_EN
        .volume      (volume),
`endif
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // ROM stand-in: data is the low bits of the address
    assign rom_data = rom_addr[DATA_W-1:0];

    function automatic int rom_value(int addr);
        int v;
        v = addr % 16;
`ifdef PCM_STREAM_PLAYER_VOLUME_EN
        v = v >> (3 - int'(volume));
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_active = 0; m_held = 0; m_fin = 0;
        m_pos = 0; m_first = 0; m_last = 0; m_elapsed = 0; m_sample = 0;
        exp_q.delete();
    endtask

    // One clock of playback behaviour, applied with the inputs seen at the edge
    task automatic model_step();
        if (stop) begin
            m_active = 0; m_held = 0; m_fin = 0; m_sample = 0; m_elapsed = 0;
        end else if (start) begin
            m_first = int'(start_addr); m_last = int'(end_addr);
            m_pos = m_first; m_elapsed = 0; m_fin = 0;
            m_active = 1; m_held = pause;
        end else if (m_active && m_held) begin
            if (!pause) m_held = 0;
        end else if (m_active) begin
            if (pause) begin
                m_held = 1;
            end else if (m_elapsed == LIMIT) begin
                m_elapsed = 0;
                m_sample = rom_value(m_pos);
                exp_q.push_back(m_sample);
                if (m_pos == m_last) begin
                    if (loop_en) m_pos = m_first;
                    else begin m_active = 0; m_fin = 1; end
                end else begin
                    m_pos = (m_pos + 1) % ASPACE;
                end
            end else begin
                m_elapsed++;
            end
        end
    endtask

    task automatic cyc(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst) model_step();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(int sa, int ea, bit lp);
        start_addr = ADDR_W'(sa); end_addr = ADDR_W'(ea); loop_en = lp;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Scoreboard monitor: strobes pop the queue, status is checked every cycle
    always @(negedge clk) begin
        if (checking && !rst) begin
            total++;
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe: unexpected sample_valid, sample=%0d at %0t", sample, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(sample) != e) begin
                        bad++;
                        $display("FAIL sample: got %0d expected %0d at %0t", sample, e, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL strobe: missing sample_valid, expected sample %0d at %0t", exp_q[0], $time);
                void'(exp_q.pop_front());
            end
            total++;
            if (busy !== m_active || done !== m_fin || int'(rom_addr) != m_pos || int'(sample) != m_sample) begin
                bad++;
                $display("FAIL status: busy=%0b done=%0b rom_addr=%0d sample=%0d expected busy=%0b done=%0b rom_addr=%0d sample=%0d at %0t",
                         busy, done, rom_addr, sample, m_active, m_fin, m_pos, m_sample, $time);
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sample !== '0 || sample_valid !== 1'b0 || rom_addr !== '0) begin
            bad++;
            $display("FAIL reset_init: busy=%0b done=%0b sample=%0d valid=%0b rom_addr=%0d expected all 0",
                     busy, done, sample, sample_valid, rom_addr);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        checking = 1'b1;
        cyc(3);

        // one-shot 5..7
        pulse_start(5, 7, 0);
        cyc(20);

        // loop through address wrap
        pulse_start(ASPACE - 2, 1, 1);
        cyc(40);
        stop = 1'b1; cyc(1); stop = 1'b0;
        cyc(3);

        // pause during one-shot: raise 2 cycles after the second sample
        pulse_start(5, 7, 0);
        cyc(8 + 2);
        pause = 1'b1; cyc(10);
        pause = 1'b0; cyc(10);

        // stop and start colliding
        pulse_start(8, 12, 1);
        cyc(6);
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
        cyc(5);
        pulse_start(8, 12, 1);
        cyc(12);

        // pause ignored in DONE / IDLE, start while paused lands in PAUSED
        pulse_start(3, 3, 0);
        cyc(6);
        pause = 1'b1; cyc(3);
        pulse_start(9, 10, 0);
        cyc(3);
        pause = 1'b0; cyc(12);

`ifdef PCM_STREAM_PLAYER_VOLUME_EN
        for (int v = 3; v >= 0; v--) begin
            volume = 2'(v);
            pulse_start(12, 12, 0);
            cyc(6);
        end
        volume = 2'd3;
`endif

        // async reset in the middle of a run, between clock edges
        pulse_start(20, 40, 1);
        cyc(9);
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sample !== '0 || sample_valid !== 1'b0 || rom_addr !== '0) begin
            bad++;
            $display("FAIL reset_async: busy=%0b done=%0b sample=%0d valid=%0b rom_addr=%0d expected all 0",
                     busy, done, sample, sample_valid, rom_addr);
        end
        cyc(2);
        rst = 1'b0;
        cyc(12);

        // random control traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            if ($urandom_range(0, 99) == 0) stop = 1'b1;
`ifdef PCM_STREAM_PLAYER_VOLUME_EN
            if ($urandom_range(0, 29) == 0) volume = 2'($urandom_range(0, 3));
`endif
            if ($urandom_range(0, 59) == 0) begin
                int sa;
                sa = (i % 5 == 0) ? ASPACE - int'($urandom_range(1, 4)) : int'($urandom_range(0, ASPACE - 1));
                start_addr = ADDR_W'(sa);
                end_addr   = ADDR_W'((sa + int'($urandom_range(0, 7))) % ASPACE);
                loop_en    = 1'($urandom_range(0, 1));
                start = 1'b1;
            end
            cyc(1);
            start = 1'b0;
            stop  = 1'b0;
        end
        pause = 1'b0;
        cyc(2);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected strobes never seen, expected 0 outstanding", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
